spike_rate_monitor: RTL and testbench
=====================================

// Module: spike_rate_monitor
// PURPOSE
//  Downstream observer for the LIF network: counts spikes on the four network spike lines
//  (spike_1, spike_2, spike_3, spike_output) over a programmable window of clk cycles.
//  - Publishes per-channel rates plus the index of the most active channel.
//  - Results go out through a valid/ready handshake to the readout/IO mux.
// PARAMETERS
//  N_CH   4  number of spike channels monitored (bit i of spike_in = channel i)
//  CNT_W  6  per-channel count width; counts saturate at 2^CNT_W-1
//  WIN_W  8  window length register width; window_len==0 means 2^WIN_W cycles
// PORTS
//  clk           in   1            system clock, all logic on posedge
//  reset         in   1            asynchronous, active-low reset
//  enable        in   1            1 = run back-to-back windows; 0 = abort/idle
//  window_len    in   WIN_W        window length in cycles, sampled at window start
//  spike_in      in   N_CH         spike pulses {spike_output,spike_3,spike_2,spike_1}
//  clear_ovr     in   1            clears sticky overrun flag
//  rate_out      out  N_CH*CNT_W   latched counts, channel i at [i*CNT_W +: CNT_W]
//  winner        out  clog2(N_CH)  channel with max latched count; ties -> lowest index
//  rate_valid    out  1            result available
//  rate_ready    in   1            consumer accepts result when rate_valid&&rate_ready
//  overrun       out  1            sticky: a result was overwritten before acceptance
//  busy          out  1            1 while in COUNT state
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; counters, timer, rate_out, winner,
//   rate_valid, overrun, busy all 0.
//  FSM states IDLE, COUNT:
//  - IDLE & enable=1 -> COUNT next cycle. Sample window_len (0 -> 2^WIN_W) and clear counters.
//  - COUNT: each cycle, cnt[i] += spike_in[i], saturating at 2^CNT_W-1; timer decrements.
//  - Last window cycle (timer==1): final counts include that cycle's spikes.
//    - Next cycle: rate_out/winner loaded, rate_valid=1, counters cleared.
//    - A new window starts with window_len re-sampled if enable=1; else -> IDLE.
//    - No dead cycle between windows. Result latency = 1 cycle after last window cycle.
//  - enable=0 in COUNT: abort next cycle -> IDLE. Partial counts discarded.
//    rate_out/rate_valid untouched.
//  Handshake:
//  - rate_valid stays 1 and rate_out/winner stay stable until rate_valid&&rate_ready.
//  - The accept cycle drops rate_valid next cycle, unless a new result loads that same cycle.
//  - New result while rate_valid=1 and not accepted that cycle:
//    overwrite rate_out/winner, rate_valid stays 1, overrun<=1.
//  - New result with simultaneous accept: load, no overrun.
//  - overrun holds until clear_ovr=1 or reset. Set wins over clear in the same cycle.
//  - winner is computed from the final counts at load time and registered with rate_out.
//  - window_len changes mid-window have no effect until the next window start.
//  - Counts never wrap. Timer width WIN_W+1 to hold 2^WIN_W.
// STRUCTURE
//  Shared package lif_pkg: LIF_N_CH=4, LIF_CNT_W=6, LIF_WIN_W=8, FSM state
//   encodings (MON_IDLE, MON_COUNT), and the spike channel index constants.
//  One sub-module: spike_counter_sat
//   - Inputs: clk, reset, clr, inc. Output: count (CNT_W, saturating).
//   - Instanced N_CH times.
//  Top holds the FSM, timer, output registers, winner compare tree and handshake.
// TESTING
//  1. Reset mid-window (spikes active): all outputs 0 immediately. No rate_valid until
//     a full new window completes after reset release.
//  2. window_len=10, ch0 pulses every 2nd cycle, ch2 every cycle, ready=1:
//     rate_out ch0=5, ch2=10, others 0; winner=2; valid 1 cycle, 11 cycles after start.
//  3. window_len=100, ch1 spikes every cycle: ch1 count=63 (saturated), no wrap, winner=1.
//  4. ready=0 for 2 windows of len 8: second result overwrites, overrun=1.
//     clear_ovr -> 0; ready=1 -> valid drops next cycle.
//  5. enable low at cycle 5 of a len-20 window: busy drops, no result, prior rate_out kept.
//     Re-enable -> fresh 20-cycle window from zero counts.
//  6. Equal counts ch1=ch3=4, window_len=0 (256 cycles): winner=1, valid after 257 cycles.
//     Accept on the same cycle as next result -> no overrun.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants for the LIF network observers: default widths, monitor FSM encodings
// and the spike channel index map.
package lif_pkg;

  localparam int unsigned LIF_N_CH  = 4;
  localparam int unsigned LIF_CNT_W = 6;
  localparam int unsigned LIF_WIN_W = 8;

  localparam logic [0:0] MON_IDLE  = 1'b0;
  localparam logic [0:0] MON_COUNT = 1'b1;

  // Bit positions of the network spike lines on spike_in_i.
  localparam int unsigned CH_SPIKE_1   = 0;
  localparam int unsigned CH_SPIKE_2   = 1;
  localparam int unsigned CH_SPIKE_3   = 2;
  localparam int unsigned CH_SPIKE_OUT = 3;

endpackage

// File: rtl/spike_counter_sat.sv
// Per-channel spike counter that saturates at all-ones instead of wrapping.
module spike_counter_sat #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed spike-rate monitor: counts spikes per channel over a programmable window and
// publishes the counts plus the most active channel through a valid/ready handshake.
module spike_rate_monitor
  import lif_pkg::*;
#(
  parameter int unsigned N_CH  = LIF_N_CH,
  parameter int unsigned CNT_W = LIF_CNT_W,
  parameter int unsigned WIN_W = LIF_WIN_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [WIN_W-1:0]         window_len_i,
  input  logic [N_CH-1:0]          spike_in_i,
  input  logic                     clear_ovr_i,
  output logic [N_CH*CNT_W-1:0]    rate_out_o,
  output logic [$clog2(N_CH)-1:0]  winner_o,
  output logic                     rate_valid_o,
  input  logic                     rate_ready_i,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int unsigned WinW = $clog2(N_CH);
  localparam int unsigned TmrW = WIN_W + 1;

  logic [0:0]                   state_q, state_d;
  logic [TmrW-1:0]              timer_q, timer_d;
  logic [TmrW-1:0]              win_cycles;
  logic [N_CH-1:0][CNT_W-1:0]   cnt, cnt_fin, rate_q, rate_d;
  logic [WinW-1:0]              winner_q, winner_d, win_best;
  logic                         valid_q, valid_d, overrun_q, overrun_d;
  logic                         counting, last, load, accept, cnt_clr;

  // A zero length register selects the longest window, 2^WIN_W cycles.
  assign win_cycles = (window_len_i == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len_i};

  assign counting = (state_q == MON_COUNT);
  assign last     = counting && (timer_q == TmrW'(1));
  assign load     = last;
  assign accept   = valid_q && rate_ready_i;
  assign cnt_clr  = !counting || last || !enable_i;

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    spike_counter_sat #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .inc_i  (spike_in_i[g]),
      .count_o(cnt[g])
    );
  end

  // Final counts include the spikes of the last window cycle itself.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_fin[i] = (spike_in_i[i] && (cnt[i] != '1)) ? cnt[i] + CNT_W'(1) : cnt[i];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    win_best = '0;
    for (int unsigned i = 1; i < N_CH; i++) begin
      if (cnt_fin[i] > cnt_fin[win_best]) begin
        win_best = WinW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      MON_IDLE: begin
        if (enable_i) begin
          state_d = MON_COUNT;
          timer_d = win_cycles;
        end
      end
      MON_COUNT: begin
        if (last) begin
          if (enable_i) begin
            timer_d = win_cycles;
          end else begin
            state_d = MON_IDLE;
            timer_d = '0;
          end
        end else if (!enable_i) begin
          state_d = MON_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TmrW'(1);
        end
      end
      default: begin
        state_d = MON_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    rate_d    = rate_q;
    winner_d  = winner_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      rate_d   = cnt_fin;
      winner_d = win_best;
      valid_d  = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    // An unaccepted result being replaced sets the flag; set beats clear.
    if (load && valid_q && !rate_ready_i) begin
      overrun_d = 1'b1;
    end else if (clear_ovr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MON_IDLE;
      timer_q   <= '0;
      rate_q    <= '0;
      winner_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rate_q    <= rate_d;
      winner_q  <= winner_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rate_out_o   = rate_q;
  assign winner_o     = winner_q;
  assign rate_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = counting;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: directed scenarios plus random traffic, all compared
// against a window-level reference model.
module tb_spike_rate_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [7:0]  window_len_i;
  logic [3:0]  spike_in_i;
  logic        clear_ovr_i;
  logic        rate_ready_i;
  logic [23:0] rate_out_o;
  logic [1:0]  winner_o;
  logic        rate_valid_o;
  logic        overrun_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_run;
  int m_left;
  int m_cnt[4];
  int m_rate[4];
  int m_win;
  bit m_valid;
  bit m_ovr;

  always #5 clk_i = ~clk_i;

  spike_rate_monitor u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .window_len_i(window_len_i),
    .spike_in_i  (spike_in_i),
    .clear_ovr_i (clear_ovr_i),
    .rate_out_o  (rate_out_o),
    .winner_o    (winner_o),
    .rate_valid_o(rate_valid_o),
    .rate_ready_i(rate_ready_i),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_run   = 0;
    m_left  = 0;
    m_win   = 0;
    m_valid = 0;
    m_ovr   = 0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_rate[i] = 0;
    end
  endfunction

  // One clock edge of the monitor as seen from the window rules.
  function automatic void model_clock(input bit e, input logic [7:0] l, input logic [3:0] s,
                                      input bit c, input bit r);
    int  fin[4];
    int  wlen;
    bit  load;
    bit  acc;
    load = 0;
    acc  = m_valid && r;
    wlen = (l == 0) ? 256 : int'(l);
    for (int i = 0; i < 4; i++) begin
      fin[i] = m_cnt[i] + int'(s[i]);
      if (fin[i] > 63) fin[i] = 63;
    end
    if (m_run) begin
      if (m_left == 1) begin
        load  = 1;
        m_win = 0;
        for (int i = 0; i < 4; i++) m_rate[i] = fin[i];
        for (int i = 1; i < 4; i++) if (fin[i] > fin[m_win]) m_win = i;
        if (e) begin
          m_left = wlen;
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
          m_run = 0;
        end
      end else if (!e) begin
        m_run = 0;
      end else begin
        for (int i = 0; i < 4; i++) m_cnt[i] = fin[i];
        m_left--;
      end
    end else if (e) begin
      m_run  = 1;
      m_left = wlen;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    if (load && m_valid && !r) m_ovr = 1;
    else if (c) m_ovr = 0;
    if (load) m_valid = 1;
    else if (acc) m_valid = 0;
  endfunction

  function automatic logic [23:0] model_rate();
    logic [23:0] v;
    for (int i = 0; i < 4; i++) v[i*6 +: 6] = 6'(m_rate[i]);
    return v;
  endfunction

  task automatic tick(input bit e, input logic [7:0] l, input logic [3:0] s, input bit c,
                      input bit r);
    enable_i     = e;
    window_len_i = l;
    spike_in_i   = s;
    clear_ovr_i  = c;
    rate_ready_i = r;
    @(posedge clk_i);
    model_clock(e, l, s, c, r);
    #1;
    check_eq("rate_out", 32'(rate_out_o), 32'(model_rate()));
    check_eq("winner", 32'(winner_o), 32'(m_win));
    check_eq("rate_valid", 32'(rate_valid_o), 32'(m_valid));
    check_eq("overrun", 32'(overrun_o), 32'(m_ovr));
    check_eq("busy", 32'(busy_o), 32'(m_run));
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    #3 rst_ni = 1'b0;
    #1;
    check_eq("rst_rate", 32'(rate_out_o), 32'h0);
    check_eq("rst_winner", 32'(winner_o), 32'h0);
    check_eq("rst_valid", 32'(rate_valid_o), 32'h0);
    check_eq("rst_overrun", 32'(overrun_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    model_reset();
    enable_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    enable_i     = 1'b0;
    window_len_i = '0;
    spike_in_i   = '0;
    clear_ovr_i  = 1'b0;
    rate_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick(0, 8'd0, 4'b0000, 0, 0);

    // len 10: ch0 every other cycle, ch2 every cycle
    tick(1, 8'd10, 4'b0000, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      tick(1, 8'd10, {1'b0, 1'b1, 1'b0, 1'(i % 2)}, 0, 1);
      if (i == 9) check_eq("t2_early", 32'(rate_valid_o), 32'h0);
    end
    check_eq("t2_rate", 32'(rate_out_o), 32'h00A005);
    check_eq("t2_winner", 32'(winner_o), 32'h2);
    check_eq("t2_valid", 32'(rate_valid_o), 32'h1);
    tick(1, 8'd10, 4'b1111, 0, 1);
    check_eq("t2_drop", 32'(rate_valid_o), 32'h0);
    repeat (3) tick(1, 8'd10, 4'b1111, 0, 1);

    // Reset mid-window, then a full window must elapse before any result
    do_reset();
    tick(1, 8'd10, 4'b0000, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      tick(1, 8'd10, 4'b0011, 0, 1);
      if (i == 9) check_eq("t1_novalid", 32'(rate_valid_o), 32'h0);
    end
    check_eq("t1_valid", 32'(rate_valid_o), 32'h1);
    tick(0, 8'd10, 4'b0000, 0, 1);

    // Saturation: ch1 for 100 cycles
    tick(1, 8'd100, 4'b0000, 0, 1);
    repeat (100) tick(1, 8'd100, 4'b0010, 0, 1);
    check_eq("t3_rate", 32'(rate_out_o), 32'h000FC0);
    check_eq("t3_winner", 32'(winner_o), 32'h1);
    tick(0, 8'd100, 4'b0000, 0, 1);

    // Overrun with ready low across two windows
    tick(1, 8'd8, 4'b0000, 0, 0);
    repeat (8) tick(1, 8'd8, 4'b1000, 0, 0);
    check_eq("t4_first", 32'(rate_out_o), 32'h200000);
    check_eq("t4_noovr", 32'(overrun_o), 32'h0);
    repeat (8) tick(1, 8'd8, 4'b0001, 0, 0);
    check_eq("t4_second", 32'(rate_out_o), 32'h000008);
    check_eq("t4_ovr", 32'(overrun_o), 32'h1);
    tick(0, 8'd8, 4'b0000, 1, 0);
    check_eq("t4_clr", 32'(overrun_o), 32'h0);
    check_eq("t4_hold", 32'(rate_valid_o), 32'h1);
    tick(0, 8'd8, 4'b0000, 0, 1);
    check_eq("t4_accept", 32'(rate_valid_o), 32'h0);

    // Abort at cycle 5 of a 20-cycle window, then a fresh window
    tick(1, 8'd20, 4'b0000, 0, 1);
    repeat (4) tick(1, 8'd20, 4'b0100, 0, 1);
    tick(0, 8'd20, 4'b0100, 0, 1);
    check_eq("t5_busy", 32'(busy_o), 32'h0);
    check_eq("t5_kept", 32'(rate_out_o), 32'h000008);
    check_eq("t5_noresult", 32'(rate_valid_o), 32'h0);
    tick(1, 8'd20, 4'b0000, 0, 1);
    repeat (20) tick(1, 8'd20, 4'b0100, 0, 1);
    check_eq("t5_fresh", 32'(rate_out_o), 32'h014000);
    tick(0, 8'd20, 4'b0000, 0, 1);

    // 256-cycle window with a tie, then accept coinciding with the next load
    tick(1, 8'd0, 4'b0000, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      tick(1, 8'd0, (i <= 4) ? 4'b1010 : 4'b0000, 0, 0);
      if (i == 255) check_eq("t6_early", 32'(rate_valid_o), 32'h0);
    end
    check_eq("t6_rate", 32'(rate_out_o), 32'h100100);
    check_eq("t6_winner", 32'(winner_o), 32'h1);
    for (int i = 1; i <= 256; i++) tick(1, 8'd0, 4'b0000, 0, (i == 256));
    check_eq("t6_noovr", 32'(overrun_o), 32'h0);
    check_eq("t6_valid", 32'(rate_valid_o), 32'h1);
    check_eq("t6_zero", 32'(rate_out_o), 32'h0);
    tick(0, 8'd0, 4'b0000, 0, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          e;
      bit          c;
      bit          r;
      logic [7:0]  l;
      logic [3:0]  s;
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      s = 4'($urandom);
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick(e, l, s, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
